// File: rtl/wb_csr_ctrl.sv
// WB-stage retire controller: issues CSR read/write, commits exceptions, interrupts and ertn,
// writes the GPR file and holds the pipeline redirect until pre-IF accepts it.
module wb_csr_ctrl #(
    parameter bit         REFETCH_ON_CSRW = 1'b1,
    parameter logic [5:0] ECODE_INT       = 6'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [2:0]  ms_op,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_rd_value,
    input  logic [31:0] ms_rj_value,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        ms_ex,
    input  logic [5:0]  ms_ecode,
    input  logic [8:0]  ms_esubcode,
    output logic        csr_re,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    input  logic [31:0] csr_rvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_pc,
    input  logic        has_int,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush_valid,
    output logic [31:0] flush_target,
    input  logic        flush_ready
);

    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_SYSCALL = 3'd5;
    localparam logic [2:0] OP_BREAK   = 3'd6;

    typedef enum logic [1:0] {EMPTY, VALID, FLUSH} state_t;

    state_t      state;
    logic [31:0] r_pc, r_rd_value, r_rj_value, r_result;
    logic [2:0]  r_op;
    logic [13:0] r_csr_num;
    logic [4:0]  r_dest;
    logic        r_ex;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;

    logic        valid, is_exc_op, take_ex, do_ertn, is_csr, is_csrw, redirect;
    logic [31:0] redirect_pc;

    assign valid       = (state == VALID);
    assign is_exc_op   = (r_op == OP_SYSCALL) || (r_op == OP_BREAK);
    assign take_ex     = valid && (has_int || r_ex || is_exc_op);
    assign do_ertn     = valid && !take_ex && (r_op == OP_ERTN);
    assign is_csr      = valid && !take_ex &&
                         ((r_op == OP_CSRRD) || (r_op == OP_CSRWR) || (r_op == OP_CSRXCHG));
    assign is_csrw     = is_csr && (r_op != OP_CSRRD);
    assign redirect    = take_ex || do_ertn || (is_csrw && REFETCH_ON_CSRW);
    assign redirect_pc = take_ex ? ex_entry : (do_ertn ? ertn_pc : r_pc + 32'd4);
    assign ws_allowin  = (state != FLUSH);

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            flush_valid  <= 1'b0;
            flush_target <= 32'd0;
        end else begin
            case (state)
                EMPTY, VALID: begin
                    if (redirect) begin
                        state        <= FLUSH;
                        flush_valid  <= 1'b1;
                        flush_target <= redirect_pc;
                    end else begin
                        state <= ms_to_ws_valid ? VALID : EMPTY;
                    end
                end
                FLUSH: begin
                    if (flush_ready) begin
                        state       <= EMPTY;
                        flush_valid <= 1'b0;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while state is VALID.
    always_ff @(posedge clk) begin
        if (ws_allowin && ms_to_ws_valid) begin
            r_pc       <= ms_pc;
            r_op       <= ms_op;
            r_csr_num  <= ms_csr_num;
            r_rd_value <= ms_rd_value;
            r_rj_value <= ms_rj_value;
            r_dest     <= ms_dest;
            r_result   <= ms_result;
            r_ex       <= ms_ex;
            r_ecode    <= ms_ecode;
            r_esubcode <= ms_esubcode;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        wb_ex       = take_ex;
        wb_ecode    = 6'd0;
        wb_esubcode = 9'd0;
        wb_pc       = 32'd0;
        ertn_flush  = do_ertn;
        csr_re      = is_csr;
        csr_we      = is_csrw;
        csr_num     = valid ? r_csr_num : 14'd0;
        csr_wmask   = 32'd0;
        csr_wvalue  = 32'd0;
        rf_we       = valid && !take_ex && (r_op != OP_ERTN) && (r_dest != 5'd0);
        rf_waddr    = 5'd0;
        rf_wdata    = 32'd0;

        // Interrupt preempts the inst, so ERA points at it and nothing else retires.
        if (take_ex) begin
            wb_pc = r_pc;
            if (has_int) begin
                wb_ecode = ECODE_INT;
            end else if (r_ex) begin
                wb_ecode    = r_ecode;
                wb_esubcode = r_esubcode;
            end else begin
                wb_ecode = (r_op == OP_SYSCALL) ? 6'h0B : 6'h0C;
            end
        end
        if (is_csrw) begin
            csr_wmask  = (r_op == OP_CSRXCHG) ? r_rj_value : 32'hFFFF_FFFF;
            csr_wvalue = r_rd_value;
        end
        if (rf_we) begin
            rf_waddr = r_dest;
            rf_wdata = is_csr ? csr_rvalue : r_result;
        end
    end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Bench for wb_csr_ctrl: table of retiring insts checked through a scoreboard queue,
// plus hand-written sequences for back-to-back retire, held redirect and reset during FLUSH.
module tb_wb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_rd_value, ms_rj_value, ms_result;
    logic [2:0]  ms_op;
    logic [13:0] ms_csr_num, csr_num;
    logic [4:0]  ms_dest, rf_waddr;
    logic        ms_ex, has_int, flush_ready;
    logic [5:0]  ms_ecode, wb_ecode;
    logic [8:0]  ms_esubcode, wb_esubcode;
    logic        csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush_valid;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, wb_pc, ex_entry, ertn_pc;
    logic [31:0] rf_wdata, flush_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_csr_ctrl #(.REFETCH_ON_CSRW(1'b1), .ECODE_INT(6'h00)) dut (
        .clk(clk), .rst(rst),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_op(ms_op), .ms_csr_num(ms_csr_num),
        .ms_rd_value(ms_rd_value), .ms_rj_value(ms_rj_value), .ms_dest(ms_dest),
        .ms_result(ms_result), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
        .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .ertn_flush(ertn_flush), .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush_valid(flush_valid), .flush_target(flush_target), .flush_ready(flush_ready)
    );

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [13:0] num;
        logic [31:0] rd, rj, result, rvalue, entry, era;
        logic [4:0]  dest;
        logic        ex, has_int;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        e_wb_ex, e_ertn, e_re, e_we, e_rf_we, e_flush;
        logic [5:0]  e_ecode;
        logic [8:0]  e_esub;
        logic [31:0] e_wmask, e_wvalue, e_rf_wdata, e_target;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t idle(input int id);
        vec_t t;
        t = '{id: id, op: 3'd0, pc: 32'd0, num: 14'd0, rd: 32'd0, rj: 32'd0, result: 32'd0,
              rvalue: 32'd0, entry: 32'h1C00_8000, era: 32'h1C00_0300, dest: 5'd0,
              ex: 1'b0, has_int: 1'b0, ecode: 6'd0, esub: 9'd0,
              e_wb_ex: 1'b0, e_ertn: 1'b0, e_re: 1'b0, e_we: 1'b0, e_rf_we: 1'b0, e_flush: 1'b0,
              e_ecode: 6'd0, e_esub: 9'd0, e_wmask: 32'd0, e_wvalue: 32'd0,
              e_rf_wdata: 32'd0, e_target: 32'd0};
        return t;
    endfunction

    task automatic drive(input vec_t v);
        ms_pc = v.pc;  ms_op = v.op;  ms_csr_num = v.num;
        ms_rd_value = v.rd;  ms_rj_value = v.rj;  ms_dest = v.dest;  ms_result = v.result;
        ms_ex = v.ex;  ms_ecode = v.ecode;  ms_esubcode = v.esub;
        has_int = v.has_int;  csr_rvalue = v.rvalue;  ex_entry = v.entry;  ertn_pc = v.era;
    endtask

    task automatic compare_retire(input vec_t e);
        string p;
        p = $sformatf("v%0d", e.id);
        check({p, " wb_ex"},      32'(wb_ex),      32'(e.e_wb_ex));
        check({p, " ertn_flush"}, 32'(ertn_flush), 32'(e.e_ertn));
        check({p, " csr_re"},     32'(csr_re),     32'(e.e_re));
        check({p, " csr_we"},     32'(csr_we),     32'(e.e_we));
        check({p, " csr_num"},    32'(csr_num),    32'(e.num));
        check({p, " rf_we"},      32'(rf_we),      32'(e.e_rf_we));
        if (e.e_wb_ex) begin
            check({p, " wb_ecode"},    32'(wb_ecode),    32'(e.e_ecode));
            check({p, " wb_esubcode"}, 32'(wb_esubcode), 32'(e.e_esub));
            check({p, " wb_pc"},       wb_pc,            e.pc);
        end
        if (e.e_we) begin
            check({p, " csr_wmask"},  csr_wmask,  e.e_wmask);
            check({p, " csr_wvalue"}, csr_wvalue, e.e_wvalue);
        end
        if (e.e_rf_we) begin
            check({p, " rf_waddr"}, 32'(rf_waddr), 32'(e.dest));
            check({p, " rf_wdata"}, rf_wdata,      e.e_rf_wdata);
        end
    endtask

    // Load one inst, wait (bounded) for its retire cycle, compare, then check the redirect.
    task automatic apply_vec(input vec_t v, input bit release_flush);
        vec_t e;
        bit   got;
        @(negedge clk);
        drive(v);
        ms_to_ws_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 ms_to_ws_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk);
            if (wb_ex || ertn_flush || csr_re || csr_we || rf_we) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d retire_timeout: no retire pulse within 4 cycles", e.id);
            return;
        end
        compare_retire(e);
        @(negedge clk);
        check($sformatf("v%0d flush_valid", e.id), 32'(flush_valid), 32'(e.e_flush));
        if (e.e_flush) begin
            check($sformatf("v%0d flush_target", e.id), flush_target, e.e_target);
            check($sformatf("v%0d ws_allowin_in_flush", e.id), 32'(ws_allowin), 32'd0);
            if (release_flush) begin
                flush_ready = 1'b1;
                @(negedge clk);
                flush_ready = 1'b0;
                check($sformatf("v%0d flush_released", e.id), 32'(flush_valid), 32'd0);
                check($sformatf("v%0d allowin_after", e.id), 32'(ws_allowin), 32'd1);
            end
        end
    endtask

    initial begin
        vec_t t, a, b;
        vec_t q[$];

        // csrwr with refetch
        t = idle(0);  t.op = 3'd2;  t.pc = 32'h1C00_0010;  t.num = 14'h30;  t.rd = 32'h1234;
        t.dest = 5'd5;  t.rvalue = 32'hAAAA_0001;
        t.e_re = 1;  t.e_we = 1;  t.e_wmask = 32'hFFFF_FFFF;  t.e_wvalue = 32'h1234;
        t.e_rf_we = 1;  t.e_rf_wdata = 32'hAAAA_0001;  t.e_flush = 1;  t.e_target = 32'h1C00_0014;
        vecs.push_back(t);
        // csrxchg
        t = idle(1);  t.op = 3'd3;  t.pc = 32'h1C00_0020;  t.num = 14'h04;  t.rd = 32'hFFFF_FFFF;
        t.rj = 32'h0000_00F0;  t.dest = 5'd6;  t.rvalue = 32'h1234_5678;
        t.e_re = 1;  t.e_we = 1;  t.e_wmask = 32'h0000_00F0;  t.e_wvalue = 32'hFFFF_FFFF;
        t.e_rf_we = 1;  t.e_rf_wdata = 32'h1234_5678;  t.e_flush = 1;  t.e_target = 32'h1C00_0024;
        vecs.push_back(t);
        // csrrd: no write, no refetch
        t = idle(2);  t.op = 3'd1;  t.pc = 32'h1C00_0030;  t.num = 14'h06;  t.dest = 5'd7;
        t.rvalue = 32'hDEAD_BEEF;
        t.e_re = 1;  t.e_rf_we = 1;  t.e_rf_wdata = 32'hDEAD_BEEF;
        vecs.push_back(t);
        // syscall
        t = idle(3);  t.op = 3'd5;  t.pc = 32'h1C00_0100;  t.dest = 5'd3;
        t.e_wb_ex = 1;  t.e_ecode = 6'h0B;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        vecs.push_back(t);
        // break with a different entry
        t = idle(4);  t.op = 3'd6;  t.pc = 32'h1C00_0104;  t.entry = 32'h1C00_A000;
        t.e_wb_ex = 1;  t.e_ecode = 6'h0C;  t.e_flush = 1;  t.e_target = 32'h1C00_A000;
        vecs.push_back(t);
        // interrupt preempts ertn
        t = idle(5);  t.op = 3'd4;  t.pc = 32'h1C00_0200;  t.has_int = 1;
        t.e_wb_ex = 1;  t.e_ecode = 6'h00;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        vecs.push_back(t);
        // ertn returns to ERA
        t = idle(6);  t.op = 3'd4;  t.pc = 32'h1C00_0204;  t.era = 32'h1C00_0300;
        t.e_ertn = 1;  t.e_flush = 1;  t.e_target = 32'h1C00_0300;
        vecs.push_back(t);
        // plain inst
        t = idle(7);  t.pc = 32'h1C00_0208;  t.dest = 5'd9;  t.result = 32'hCAFE_F00D;
        t.e_rf_we = 1;  t.e_rf_wdata = 32'hCAFE_F00D;
        vecs.push_back(t);
        // earlier-stage exception on a csrwr suppresses the write
        t = idle(8);  t.op = 3'd2;  t.pc = 32'h1C00_0400;  t.num = 14'h30;  t.dest = 5'd5;
        t.ex = 1;  t.ecode = 6'h08;  t.esub = 9'h001;
        t.e_wb_ex = 1;  t.e_ecode = 6'h08;  t.e_esub = 9'h001;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        vecs.push_back(t);
        // csrwr at top of address space: refetch target wraps, dest 0 means no GPR write
        t = idle(9);  t.op = 3'd2;  t.pc = 32'hFFFF_FFFC;  t.num = 14'h30;  t.rd = 32'h7;  t.rvalue = 32'h9;
        t.e_re = 1;  t.e_we = 1;  t.e_wmask = 32'hFFFF_FFFF;  t.e_wvalue = 32'h7;
        t.e_flush = 1;  t.e_target = 32'h0;
        vecs.push_back(t);
        // interrupt on a plain inst
        t = idle(10);  t.pc = 32'h1C00_0600;  t.dest = 5'd8;  t.result = 32'h5;  t.has_int = 1;
        t.e_wb_ex = 1;  t.e_ecode = 6'h00;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        vecs.push_back(t);
        // ms_ex outranks syscall and carries its esubcode
        t = idle(11);  t.op = 3'd5;  t.pc = 32'h1C00_0700;  t.ex = 1;  t.ecode = 6'h0D;  t.esub = 9'h005;
        t.e_wb_ex = 1;  t.e_ecode = 6'h0D;  t.e_esub = 9'h005;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        vecs.push_back(t);

        rst = 1'b1;  ms_to_ws_valid = 1'b0;  flush_ready = 1'b0;
        drive(idle(-1));
        repeat (2) @(negedge clk);
        check("reset ws_allowin",   32'(ws_allowin),  32'd1);
        check("reset flush_valid",  32'(flush_valid), 32'd0);
        check("reset flush_target", flush_target,     32'd0);
        check("reset wb_ex",        32'(wb_ex),       32'd0);
        check("reset csr_we",       32'(csr_we),      32'd0);
        check("reset rf_we",        32'(rf_we),       32'd0);
        check("reset csr_num",      32'(csr_num),     32'd0);
        rst = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i], 1'b1);

        // Back-to-back plain insts: VALID -> VALID
        a = idle(20);  a.pc = 32'h1C00_0800;  a.dest = 5'd9;   a.result = 32'h1111_1111;
        a.e_rf_we = 1;  a.e_rf_wdata = 32'h1111_1111;
        b = idle(21);  b.pc = 32'h1C00_0804;  b.dest = 5'd10;  b.result = 32'h2222_2222;
        b.e_rf_we = 1;  b.e_rf_wdata = 32'h2222_2222;
        @(negedge clk);
        drive(a);  ms_to_ws_valid = 1'b1;  sb.push_back(a);
        @(negedge clk);
        compare_retire(sb.pop_front());
        drive(b);  sb.push_back(b);
        @(posedge clk);
        #1 ms_to_ws_valid = 1'b0;
        @(negedge clk);
        compare_retire(sb.pop_front());
        @(negedge clk);
        check("b2b empty rf_we", 32'(rf_we), 32'd0);

        // Redirect held with MEM offering an inst: nothing may load
        t = idle(30);  t.op = 3'd2;  t.pc = 32'h1C00_0500;  t.num = 14'h30;  t.rd = 32'h55;
        t.dest = 5'd4;  t.rvalue = 32'h1;
        t.e_re = 1;  t.e_we = 1;  t.e_wmask = 32'hFFFF_FFFF;  t.e_wvalue = 32'h55;
        t.e_rf_we = 1;  t.e_rf_wdata = 32'h1;  t.e_flush = 1;  t.e_target = 32'h1C00_0504;
        apply_vec(t, 1'b0);
        a = idle(31);  a.pc = 32'h1C00_0900;  a.dest = 5'd10;  a.result = 32'h3333_3333;
        drive(a);  ms_to_ws_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d ws_allowin", c),   32'(ws_allowin),  32'd0);
            check($sformatf("hold%0d flush_valid", c),  32'(flush_valid), 32'd1);
            check($sformatf("hold%0d flush_target", c), flush_target,     32'h1C00_0504);
            check($sformatf("hold%0d rf_we", c),        32'(rf_we),       32'd0);
        end
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;  ms_to_ws_valid = 1'b0;
        check("release flush_valid", 32'(flush_valid), 32'd0);
        check("release ws_allowin",  32'(ws_allowin),  32'd1);
        check("release no load",     32'(rf_we),       32'd0);
        check("release csr_num",     32'(csr_num),     32'd0);

        // Reset during FLUSH drops the redirect
        t = idle(40);  t.op = 3'd5;  t.pc = 32'h1C00_0A00;
        t.e_wb_ex = 1;  t.e_ecode = 6'h0B;  t.e_flush = 1;  t.e_target = 32'h1C00_8000;
        apply_vec(t, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstflush flush_valid",  32'(flush_valid), 32'd0);
        check("rstflush ws_allowin",   32'(ws_allowin),  32'd1);
        check("rstflush flush_target", flush_target,     32'd0);
        check("rstflush wb_ex",        32'(wb_ex),       32'd0);
        check("rstflush ertn_flush",   32'(ertn_flush),  32'd0);
        check("rstflush csr_we",       32'(csr_we),      32'd0);
        check("rstflush rf_we",        32'(rf_we),       32'd0);

        q = sb;
        check("scoreboard drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
